// File: rtl/lbu_pkg.sv
// Shared definitions for the line-buffer unit: pointer opcodes and sequencer states.
// Also used by the pointer register block for the opcode type.
package lbu_pkg;

    typedef logic [2:0] ptr_op_t;

    localparam ptr_op_t PTR_OP_NONE = 3'd0;
    localparam ptr_op_t PTR_OP_RST  = 3'd1;
    localparam ptr_op_t PTR_OP_INCR = 3'd2;
    localparam ptr_op_t PTR_OP_DECR = 3'd3;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LINE_RST,
        SEQ_STEP,
        SEQ_LINE_END,
        SEQ_FIN
    } seq_state_e;

endpackage

// File: rtl/lbu_ptr_sequencer_if.sv
// Valid/ready opcode channel from the sequencer (master) to the pointer register block (slave).
interface lbu_ptr_sequencer_if #(
    parameter int P_STRIDE_W = 3
) ();
    import lbu_pkg::*;

    logic                  ptrValid;
    logic                  ptrReady;
    ptr_op_t               ptrOp;
    logic [P_STRIDE_W-1:0] ptrStride;

    modport master (output ptrValid, ptrOp, ptrStride, input ptrReady);
    modport slave  (input ptrValid, ptrOp, ptrStride, output ptrReady);

endinterface

// File: rtl/lbu_seq_cnt.sv
// Column/row counters for the pointer sequencer, with the stride add and the
// end-of-line / end-of-frame lookahead compares the FSM branches on.
module lbu_seq_cnt
    import lbu_pkg::*;
#(
    parameter int P_COL_W    = 10,
    parameter int P_ROW_W    = 10,
    parameter int P_STRIDE_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  colClr_i,
    input  logic                  colStep_i,
    input  logic                  rowClr_i,
    input  logic                  rowInc_i,
    input  logic [P_COL_W-1:0]    cols_i,
    input  logic [P_ROW_W-1:0]    rows_i,
    input  logic [P_STRIDE_W-1:0] stride_i,
    output logic                  firstFits_o,
    output logic                  nextFits_o,
    output logic                  rowLast_o
);

    localparam logic [P_ROW_W:0] ROW_ONE = (P_ROW_W+1)'(1);

    logic [P_COL_W:0]   col_q, col_d;
    logic [P_ROW_W-1:0] row_q, row_d;
    logic [P_COL_W:0]   strideExt;
    logic [P_COL_W:0]   colSum;
    logic [P_COL_W+1:0] nextSum;

    assign strideExt = {{(P_COL_W+1-P_STRIDE_W){1'b0}}, stride_i};
    assign colSum    = col_q + strideExt;
    assign nextSum   = {1'b0, colSum} + {1'b0, strideExt};

    // firstFits: a step follows the RST; nextFits: another step follows the current one
    assign firstFits_o = strideExt < {1'b0, cols_i};
    assign nextFits_o  = nextSum < {2'b00, cols_i};
    assign rowLast_o   = ({1'b0, row_q} + ROW_ONE) == {1'b0, rows_i};

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (colClr_i) begin
            col_d = '0;
        end else if (colStep_i) begin
            col_d = colSum;
        end
        if (rowClr_i) begin
            row_d = '0;
        end else if (rowInc_i) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/lbu_ptr_sequencer.sv
// Frame-level pointer sequencer: issues RST/INCR/DECR opcodes per line and rotates the line slot.
// Optional build macro LBU_SEQ_ABORT_EN adds an abort_i port that ends a frame early without done.
module lbu_ptr_sequencer
    import lbu_pkg::*;
#(
    parameter int P_COL_W     = 10,
    parameter int P_ROW_W     = 10,
    parameter int P_STRIDE_W  = 3,
    parameter int P_NUM_LINES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [P_COL_W-1:0]             cfgCols_i,
    input  logic [P_ROW_W-1:0]             cfgRows_i,
    input  logic [P_STRIDE_W-1:0]          cfgStride_i,
    input  logic                           cfgDir_i,
    lbu_ptr_sequencer_if.master            ptr_if,
    output logic [$clog2(P_NUM_LINES)-1:0] lineSel_o,
    output logic                           busy_o,
    output logic                           done_o
`ifdef LBU_SEQ_ABORT_EN
    ,
    input  logic                           abort_i
`endif
);

    localparam int LS_W = $clog2(P_NUM_LINES);
    localparam logic [P_STRIDE_W-1:0] STRIDE_ONE = P_STRIDE_W'(1);
    localparam logic [LS_W-1:0]       LS_ONE     = LS_W'(1);

    seq_state_e            state_q;
    logic                  valid_q;
    ptr_op_t               op_q;
    logic [P_STRIDE_W-1:0] strideOut_q;
    logic [LS_W-1:0]       lineSel_q;
    logic                  busy_q;
    logic                  done_q;
    logic [P_COL_W-1:0]    cols_q;
    logic [P_ROW_W-1:0]    rows_q;
    logic [P_STRIDE_W-1:0] stride_q;
    logic                  dir_q;
`ifdef LBU_SEQ_ABORT_EN
    logic                  abortPend_q;
`endif

    logic hs;
    logic firstFits, nextFits, rowLast;

    assign hs = valid_q & ptr_if.ptrReady;

    lbu_seq_cnt #(
        .P_COL_W    (P_COL_W),
        .P_ROW_W    (P_ROW_W),
        .P_STRIDE_W (P_STRIDE_W)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .colClr_i    ((state_q == SEQ_LINE_RST) && hs),
        .colStep_i   ((state_q == SEQ_STEP) && hs),
        .rowClr_i    ((state_q == SEQ_IDLE) && start_i),
        .rowInc_i    (state_q == SEQ_LINE_END),
        .cols_i      (cols_q),
        .rows_i      (rows_q),
        .stride_i    (stride_q),
        .firstFits_o (firstFits),
        .nextFits_o  (nextFits),
        .rowLast_o   (rowLast)
    );

    // Every output is registered, so valid never depends combinationally on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEQ_IDLE;
            valid_q     <= 1'b0;
            op_q        <= PTR_OP_NONE;
            strideOut_q <= '0;
            lineSel_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cols_q      <= '0;
            rows_q      <= '0;
            stride_q    <= '0;
            dir_q       <= 1'b0;
`ifdef LBU_SEQ_ABORT_EN
            abortPend_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (start_i) begin
                        if ((cfgCols_i != '0) && (cfgRows_i != '0)) begin
                            cols_q      <= cfgCols_i;
                            rows_q      <= cfgRows_i;
                            stride_q    <= (cfgStride_i == '0) ? STRIDE_ONE : cfgStride_i;
                            dir_q       <= cfgDir_i;
                            state_q     <= SEQ_LINE_RST;
                            valid_q     <= 1'b1;
                            op_q        <= PTR_OP_RST;
                            strideOut_q <= '0;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q <= SEQ_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEQ_LINE_RST: begin
                    if (hs) begin
                        if (firstFits) begin
                            state_q     <= SEQ_STEP;
                            op_q        <= dir_q ? PTR_OP_DECR : PTR_OP_INCR;
                            strideOut_q <= stride_q;
                        end else begin
                            state_q     <= SEQ_LINE_END;
                            valid_q     <= 1'b0;
                            op_q        <= PTR_OP_NONE;
                            strideOut_q <= '0;
                            lineSel_q   <= lineSel_q + LS_ONE;
                        end
                    end
                end
                SEQ_STEP: begin
                    if (hs && !nextFits) begin
                        state_q     <= SEQ_LINE_END;
                        valid_q     <= 1'b0;
                        op_q        <= PTR_OP_NONE;
                        strideOut_q <= '0;
                        lineSel_q   <= lineSel_q + LS_ONE;
                    end
                end
                SEQ_LINE_END: begin
                    if (rowLast) begin
                        state_q <= SEQ_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= SEQ_LINE_RST;
                        valid_q     <= 1'b1;
                        op_q        <= PTR_OP_RST;
                        strideOut_q <= '0;
                    end
                end
                SEQ_FIN: begin
                    state_q <= SEQ_IDLE;
                end
                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
`ifdef LBU_SEQ_ABORT_EN
            // A stalled opcode must still complete, so abort is remembered until the handshake
            if ((state_q != SEQ_IDLE) && (state_q != SEQ_FIN) && (abort_i || abortPend_q)) begin
                if (!valid_q || ptr_if.ptrReady) begin
                    state_q     <= SEQ_IDLE;
                    valid_q     <= 1'b0;
                    op_q        <= PTR_OP_NONE;
                    strideOut_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    lineSel_q   <= lineSel_q;
                    abortPend_q <= 1'b0;
                end else begin
                    abortPend_q <= 1'b1;
                end
            end else begin
                abortPend_q <= 1'b0;
            end
`endif
        end
    end

    assign ptr_if.ptrValid  = valid_q;
    assign ptr_if.ptrOp     = op_q;
    assign ptr_if.ptrStride = strideOut_q;
    assign lineSel_o        = lineSel_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_lbu_ptr_sequencer.sv
// Directed self-checking bench for lbu_ptr_sequencer; abort scenario only with LBU_SEQ_ABORT_EN.
module tb_lbu_ptr_sequencer;
   import lbu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [9:0] cfgCols;
   logic [9:0] cfgRows;
   logic [2:0] cfgStride;
   logic       cfgDir;
   logic       ready;
   logic [1:0] lineSel;
   logic       busy;
   logic       done;
`ifdef LBU_SEQ_ABORT_EN
   logic       abort;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastHsCyc = 0;
   int doneCyc = 0;
   int doneCount = 0;
   logic [2:0] qOp[$];
   logic [2:0] qStr[$];
   logic [1:0] qLs[$];

   lbu_ptr_sequencer_if #(.P_STRIDE_W(3)) pif ();
   assign pif.ptrReady = ready;

   lbu_ptr_sequencer #(
      .P_COL_W     (10),
      .P_ROW_W     (10),
      .P_STRIDE_W  (3),
      .P_NUM_LINES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .cfgCols_i   (cfgCols),
      .cfgRows_i   (cfgRows),
      .cfgStride_i (cfgStride),
      .cfgDir_i    (cfgDir),
      .ptr_if      (pif),
      .lineSel_o   (lineSel),
      .busy_o      (busy),
      .done_o      (done)
`ifdef LBU_SEQ_ABORT_EN
      ,
      .abort_i     (abort)
`endif
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used for latency measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Handshakes are logged at the falling edge; the transfer completes on the following rising edge
   always @(negedge clk) begin
      if (rst_n && pif.ptrValid && pif.ptrReady) begin
         qOp.push_back(pif.ptrOp);
         qStr.push_back(pif.ptrStride);
         qLs.push_back(lineSel);
         lastHsCyc = cyc;
      end
      if (done) begin
         doneCount = doneCount + 1;
         doneCyc   = cyc;
      end
   end

   task automatic clearLog();
      qOp.delete();
      qStr.delete();
      qLs.delete();
   endtask

   task automatic doStart(input logic [9:0] c, input logic [9:0] r, input logic [2:0] s, input logic d);
      @(posedge clk); #1;
      cfgCols = c; cfgRows = r; cfgStride = s; cfgDir = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < maxCycles; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (pif.ptrValid !== 1'b0 || pif.ptrOp !== PTR_OP_NONE || pif.ptrStride !== 3'd0 ||
          lineSel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_values: got valid=%b op=%0d stride=%0d ls=%0d busy=%b done=%b, expected all 0",
                  pif.ptrValid, pif.ptrOp, pif.ptrStride, lineSel, busy, done);
      end
      @(negedge clk); #2;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (pif.ptrValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b done=%b, expected 0 0 0", pif.ptrValid, busy, done);
      end
   endtask

   task automatic test_basic();
      logic [2:0] expOp [6];
      logic [2:0] expStr [6];
      logic [1:0] expLs [6];
      bit ok;
      expOp  = '{PTR_OP_RST, PTR_OP_INCR, PTR_OP_INCR, PTR_OP_RST, PTR_OP_INCR, PTR_OP_INCR};
      expStr = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd3, 3'd3};
      expLs  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      clearLog();
      ready = 1'b1;
      doStart(10'd8, 10'd2, 3'd3, 1'b0);
      @(negedge clk);
      checks++;
      if (pif.ptrValid !== 1'b1 || pif.ptrOp !== PTR_OP_RST || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_first_op: got valid=%b op=%0d busy=%b, expected 1 1 1", pif.ptrValid, pif.ptrOp, busy);
      end
      waitDone(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL basic_done_timeout: got no done, expected done within 100 cycles");
      end
      checks++;
      if (qOp.size() !== 6) begin
         errors++;
         $display("[TB] FAIL basic_op_count: got %0d, expected 6", qOp.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (i < qOp.size()) begin
            checks++;
            if (qOp[i] !== expOp[i] || qStr[i] !== expStr[i] || qLs[i] !== expLs[i]) begin
               errors++;
               $display("[TB] FAIL basic_op%0d: got op=%0d stride=%0d ls=%0d, expected op=%0d stride=%0d ls=%0d",
                        i, qOp[i], qStr[i], qLs[i], expOp[i], expStr[i], expLs[i]);
            end
         end
      end
      checks++;
      if (doneCyc - lastHsCyc !== 2) begin
         errors++;
         $display("[TB] FAIL basic_done_latency: got %0d, expected 2", doneCyc - lastHsCyc);
      end
      checks++;
      if (lineSel !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_at_done: got ls=%0d busy=%b, expected ls=2 busy=0", lineSel, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_pulse: got done=%b one cycle later, expected 0", done);
      end
   endtask

   task automatic test_stride0_reverse();
      bit ok;
      clearLog();
      ready = 1'b1;
      doStart(10'd4, 10'd1, 3'd0, 1'b1);
      waitDone(100, ok);
      checks++;
      if (!ok || qOp.size() !== 4) begin
         errors++;
         $display("[TB] FAIL rev_op_count: got ok=%b count=%0d, expected ok=1 count=4", ok, qOp.size());
      end
      if (qOp.size() == 4) begin
         checks++;
         if (qOp[0] !== PTR_OP_RST || qStr[0] !== 3'd0) begin
            errors++;
            $display("[TB] FAIL rev_rst: got op=%0d stride=%0d, expected op=1 stride=0", qOp[0], qStr[0]);
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (qOp[i] !== PTR_OP_DECR || qStr[i] !== 3'd1) begin
               errors++;
               $display("[TB] FAIL rev_step%0d: got op=%0d stride=%0d, expected op=3 stride=1", i, qOp[i], qStr[i]);
            end
         end
      end
      checks++;
      if (lineSel !== 2'd3) begin
         errors++;
         $display("[TB] FAIL rev_linesel: got %0d, expected 3", lineSel);
      end
   endtask

   task automatic test_stall();
      logic [2:0] expOp [6];
      logic [2:0] expStr [6];
      logic [1:0] expLs [6];
      logic       prevStall;
      logic [2:0] prevOp;
      logic [2:0] prevStr;
      bit ok;
      expOp  = '{PTR_OP_RST, PTR_OP_INCR, PTR_OP_INCR, PTR_OP_RST, PTR_OP_INCR, PTR_OP_INCR};
      expStr = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd3, 3'd3};
      expLs  = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
      clearLog();
      ready = 1'b0;
      ok = 1'b0;
      prevStall = 1'b0;
      prevOp = '0;
      prevStr = '0;
      doStart(10'd8, 10'd2, 3'd3, 1'b0);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (prevStall) begin
            checks++;
            if (pif.ptrValid !== 1'b1 || pif.ptrOp !== prevOp || pif.ptrStride !== prevStr) begin
               errors++;
               $display("[TB] FAIL stall_hold: got valid=%b op=%0d stride=%0d, expected valid=1 op=%0d stride=%0d",
                        pif.ptrValid, pif.ptrOp, pif.ptrStride, prevOp, prevStr);
            end
         end
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         prevStall = pif.ptrValid && !ready;
         prevOp    = pif.ptrOp;
         prevStr   = pif.ptrStride;
         @(posedge clk); #1;
         ready = (k % 4 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      #1;
      ready = 1'b1;
      checks++;
      if (!ok || qOp.size() !== 6) begin
         errors++;
         $display("[TB] FAIL stall_op_count: got ok=%b count=%0d, expected ok=1 count=6", ok, qOp.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (i < qOp.size()) begin
            checks++;
            if (qOp[i] !== expOp[i] || qStr[i] !== expStr[i] || qLs[i] !== expLs[i]) begin
               errors++;
               $display("[TB] FAIL stall_op%0d: got op=%0d stride=%0d ls=%0d, expected op=%0d stride=%0d ls=%0d",
                        i, qOp[i], qStr[i], qLs[i], expOp[i], expStr[i], expLs[i]);
            end
         end
      end
      checks++;
      if (lineSel !== 2'd1) begin
         errors++;
         $display("[TB] FAIL stall_linesel: got %0d, expected 1", lineSel);
      end
   endtask

   task automatic test_zero_size();
      int d0;
      clearLog();
      ready = 1'b1;
      d0 = doneCount;
      doStart(10'd0, 10'd3, 3'd1, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pif.ptrValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_cols_done: got done=%b busy=%b valid=%b, expected 1 0 0", done, busy, pif.ptrValid);
      end
      repeat (3) @(negedge clk);
      doStart(10'd5, 10'd0, 3'd1, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || pif.ptrValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_rows_done: got done=%b valid=%b, expected 1 0", done, pif.ptrValid);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (qOp.size() !== 0 || doneCount - d0 !== 2 || lineSel !== 2'd1) begin
         errors++;
         $display("[TB] FAIL zero_no_ops: got ops=%0d dones=%0d ls=%0d, expected 0 2 1", qOp.size(), doneCount - d0, lineSel);
      end
   endtask

   task automatic test_start_busy();
      int d0;
      bit ok;
      clearLog();
      ready = 1'b1;
      d0 = doneCount;
      doStart(10'd4, 10'd1, 3'd1, 1'b0);
      @(posedge clk); #1;
      cfgCols = 10'd8; cfgRows = 10'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(100, ok);
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (!ok || qOp.size() !== 4 || doneCount - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL busy_start_ignored: got ok=%b ops=%0d dones=%0d, expected 1 4 1", ok, qOp.size(), doneCount - d0);
      end
      checks++;
      if (lineSel !== 2'd2) begin
         errors++;
         $display("[TB] FAIL busy_linesel: got %0d, expected 2", lineSel);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] expOp [4];
      logic [2:0] expStr [4];
      bit ok;
      expOp  = '{PTR_OP_RST, PTR_OP_DECR, PTR_OP_RST, PTR_OP_INCR};
      expStr = '{3'd0, 3'd1, 3'd0, 3'd2};
      clearLog();
      ready = 1'b1;
      doStart(10'd2, 10'd1, 3'd1, 1'b1);
      waitDone(50, ok);
      doStart(10'd3, 10'd1, 3'd2, 1'b0);
      @(negedge clk);
      checks++;
      if (pif.ptrValid !== 1'b1 || pif.ptrOp !== PTR_OP_RST) begin
         errors++;
         $display("[TB] FAIL b2b_restart: got valid=%b op=%0d, expected 1 1", pif.ptrValid, pif.ptrOp);
      end
      waitDone(50, ok);
      checks++;
      if (!ok || qOp.size() !== 4) begin
         errors++;
         $display("[TB] FAIL b2b_op_count: got ok=%b count=%0d, expected ok=1 count=4", ok, qOp.size());
      end
      for (int i = 0; i < 4; i++) begin
         if (i < qOp.size()) begin
            checks++;
            if (qOp[i] !== expOp[i] || qStr[i] !== expStr[i]) begin
               errors++;
               $display("[TB] FAIL b2b_op%0d: got op=%0d stride=%0d, expected op=%0d stride=%0d",
                        i, qOp[i], qStr[i], expOp[i], expStr[i]);
            end
         end
      end
      checks++;
      if (lineSel !== 2'd0) begin
         errors++;
         $display("[TB] FAIL b2b_linesel: got %0d, expected 0", lineSel);
      end
   endtask

   task automatic test_reset_midframe();
      int d0;
      ready = 1'b1;
      doStart(10'd8, 10'd2, 3'd1, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pif.ptrValid !== 1'b0 || pif.ptrOp !== PTR_OP_NONE || pif.ptrStride !== 3'd0 ||
          lineSel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_values: got valid=%b op=%0d stride=%0d ls=%0d busy=%b done=%b, expected all 0",
                  pif.ptrValid, pif.ptrOp, pif.ptrStride, lineSel, busy, done);
      end
      @(negedge clk); #2;
      rst_n = 1'b1;
      d0 = doneCount;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (doneCount !== d0 || pif.ptrValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_quiet: got dones=%0d valid=%b busy=%b, expected 0 0 0", doneCount - d0, pif.ptrValid, busy);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      clearLog();
      ready = 1'b1;
      doStart(10'd3, 10'd6, 3'd2, 1'b0);
      waitDone(200, ok);
      checks++;
      if (!ok || qOp.size() !== 12) begin
         errors++;
         $display("[TB] FAIL wrap_op_count: got ok=%b count=%0d, expected ok=1 count=12", ok, qOp.size());
      end
      if (qOp.size() == 12) begin
         checks++;
         if (qLs[6] !== 2'd3 || qLs[8] !== 2'd0 || qOp[7] !== PTR_OP_INCR || qStr[7] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL wrap_slots: got ls6=%0d ls8=%0d op7=%0d str7=%0d, expected 3 0 2 2",
                     qLs[6], qLs[8], qOp[7], qStr[7]);
         end
      end
      checks++;
      if (lineSel !== 2'd2 || doneCyc - lastHsCyc !== 2) begin
         errors++;
         $display("[TB] FAIL wrap_at_done: got ls=%0d latency=%0d, expected ls=2 latency=2", lineSel, doneCyc - lastHsCyc);
      end
   endtask

`ifdef LBU_SEQ_ABORT_EN
   task automatic test_abort();
      int d0;
      bit ok;
      clearLog();
      ready = 1'b0;
      abort = 1'b0;
      d0 = doneCount;
      doStart(10'd8, 10'd2, 3'd1, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      checks++;
      if (pif.ptrValid !== 1'b1 || pif.ptrOp !== PTR_OP_RST) begin
         errors++;
         $display("[TB] FAIL abort_hold: got valid=%b op=%0d, expected 1 1", pif.ptrValid, pif.ptrOp);
      end
      @(negedge clk);
      checks++;
      if (pif.ptrValid !== 1'b0 || busy !== 1'b0 || pif.ptrOp !== PTR_OP_NONE) begin
         errors++;
         $display("[TB] FAIL abort_idle: got valid=%b busy=%b op=%0d, expected 0 0 0", pif.ptrValid, busy, pif.ptrOp);
      end
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (qOp.size() !== 1 || doneCount !== d0 || lineSel !== 2'd2) begin
         errors++;
         $display("[TB] FAIL abort_quiet: got ops=%0d dones=%0d ls=%0d, expected 1 0 2", qOp.size(), doneCount - d0, lineSel);
      end
      clearLog();
      doStart(10'd2, 10'd1, 3'd1, 1'b0);
      waitDone(50, ok);
      checks++;
      if (!ok || qOp.size() !== 2 || lineSel !== 2'd3) begin
         errors++;
         $display("[TB] FAIL abort_restart: got ok=%b ops=%0d ls=%0d, expected 1 2 3", ok, qOp.size(), lineSel);
      end
   endtask
`endif

   // Test sequence: reset, then each directed scenario in turn, then the summary
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cfgCols = '0;
      cfgRows = '0;
      cfgStride = '0;
      cfgDir = 1'b0;
      ready = 1'b0;
`ifdef LBU_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_basic();
      test_stride0_reverse();
      test_stall();
      test_zero_size();
      test_start_busy();
      test_back_to_back();
      test_reset_midframe();
      test_wrap();
`ifdef LBU_SEQ_ABORT_EN
      test_abort();
`endif
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lbu_ptr_sequencer.md
# lbu_ptr_sequencer

Frame-level sequencer for the line-buffer unit pointer registers. On a start request it latches a frame geometry and scan direction, then issues a paced stream of pointer opcodes (reset / increment / decrement with stride) over a valid/ready interface to the pointer register block. It also advances the active line-slot index around the line-buffer ring. It sits between the frame control logic and the pointer register block and is the only agent driving pointer updates.

## Interface
- P_COL_W, 10, width of column count
- P_ROW_W, 10, width of row count
- P_STRIDE_W, 3, width of stride field (unsigned magnitude)
- P_NUM_LINES, 4, line slots in the ring; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- cfgCols  in  P_COL_W  columns per line; latched at accepted start
- cfgRows  in  P_ROW_W  lines per frame; latched at accepted start
- cfgStride  in  P_STRIDE_W  column step; 0 is treated as 1; latched at accepted start
- cfgDir  in  1  0 = forward (INCR), 1 = reverse (DECR); latched at accepted start
- ptrValid  out  1  opcode valid
- ptrReady  in  1  pointer block accepts
- ptrOp  out  3  opcode: NONE=0, RST=1, INCR=2, DECR=3
- ptrStride  out  P_STRIDE_W  effective stride accompanying INCR/DECR; 0 with RST
- lineSel  out  $clog2(P_NUM_LINES)  active line slot
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- abort  in  1  present only with LBU_SEQ_ABORT_EN

## Operation
- Reset values: ptrValid=0, ptrOp=NONE, ptrStride=0, lineSel=0, busy=0, done=0, state IDLE, all counters 0.
- States: IDLE, LINE_RST, STEP, LINE_END, FIN.
- IDLE:
  - If start=1 with cfgCols≠0 and cfgRows≠0: latch the config, go to LINE_RST, busy=1.
  - If either count is 0: go to FIN with no ops issued.
- LINE_RST: drive RST; on handshake, col=0, then go to STEP if stride<cfgCols, else LINE_END.
- STEP:
  - Drive INCR (cfgDir=0) or DECR (cfgDir=1), with ptrStride = effective stride.
  - On handshake, col += stride, computed in P_COL_W+1 bits.
  - When col+stride ≥ cfgCols (P_COL_W+1-bit compare, no wrap), go to LINE_END.
- Ops per line: 1 RST plus ceil(cols/stride)−1 steps. Example: cols=8, stride=3 gives RST, INCR, INCR.
- LINE_END (no op, one cycle):
  - lineSel = (lineSel+1) mod P_NUM_LINES; row += 1.
  - If row == cfgRows go to FIN, else go to LINE_RST.
- FIN: done=1 for one cycle, busy=0, return to IDLE. lineSel is retained across frames and is reset only by rst_n.
- Handshake rules:
  - A transfer occurs when ptrValid & ptrReady.
  - While ptrValid=1 & ptrReady=0, ptrOp and ptrStride are held stable and ptrValid never drops.
  - ptrValid does not depend combinationally on ptrReady.
- start while busy is ignored. Config inputs are don't-care outside an accepted start.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); no done is produced.

## Timing
- Start at cycle T (accepted) → ptrValid=1 with RST at T+1.
- With ptrReady held at 1: one op per cycle within a line, plus one bubble cycle per line for LINE_END.
- lineSel changes the cycle after the last op of a line is accepted.
- done is asserted in the cycle after the final LINE_END, i.e. 2 cycles after the last handshake. busy falls in the same cycle done rises.
- Zero-size frame: done at T+1, no ptrValid.
- Minimum start-to-start spacing: start may be reasserted in the cycle after done.

## Configuration
- LBU_SEQ_ABORT_EN defined: the abort port exists.
  - abort=1 in any non-IDLE state completes the pending handshake first, because valid may not drop.
  - It then enters IDLE with busy=0, no done, and lineSel unchanged.
  - abort in IDLE has no effect.
- LBU_SEQ_ABORT_EN undefined: there is no abort port; a frame always runs to completion or rst_n.

## Structure
- Shared package lbu_pkg holds:
  - the ptr opcode constants (NONE/RST/INCR/DECR, width 3);
  - the state enum type;
  - the opcode typedef, also used by the pointer register block.
- One sub-module, lbu_seq_cnt: column/row counters with the stride-add and end-of-line/end-of-frame compares. The FSM and handshake stay in the top module.

## Test plan
- cols=8, rows=2, stride=3, dir=0, ready=1 → RST, INCR(3), INCR(3), then RST, INCR, INCR. lineSel goes 0→1→2. done 2 cycles after the 6th handshake.
- cols=4, rows=1, stride=0, dir=1 → RST, DECR(1)×3, and ptrStride=1.
- Random ptrReady stalls, 50% duty → ptrOp/ptrStride stable during stalls, no dropped valid, same op sequence as with ready=1.
- rows=6, P_NUM_LINES=4 → lineSel wraps 3→0; at done, lineSel=2.
- cfgCols=0 or cfgRows=0 → done at T+1, zero handshakes. start during busy → ignored, and the op count is unchanged.
- rst_n pulsed mid-line, then abort mid-line (ABORT_EN build) → all outputs return to reset values / IDLE after the pending transfer, no done, the next start runs cleanly.
